// File: rtl/bus_arbiter_4.sv
// Round-robin 4:1 bus arbiter: registered one-hot grant/select, grant one cycle after req, zero-gap handover.
// Requesters hold req until done; define ARB_BURST_LIMIT_EN to preempt an owner after max_burst cycles.
module bus_arbiter_4 #(
  parameter int word_size = 32,
  parameter int max_burst = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [word_size-1:0] input_data0,
  input  logic [word_size-1:0] input_data1,
  input  logic [word_size-1:0] input_data2,
  input  logic [word_size-1:0] input_data3,
  output logic [3:0]           grant,
  output logic [1:0]           select,
  output logic [word_size-1:0] bus_data,
  output logic                 bus_valid
);

`ifdef ARB_BURST_LIMIT_EN
  localparam bit limit_en = 1'b1;
`else
  localparam bit limit_en = 1'b0;
`endif
  localparam logic [7:0] burst_last = 8'(max_burst - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       others;
  logic       burst_hit;
  logic       take;

  // Scan downward so the lowest offset from ptr is the last, winning assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        win_vld = 1'b1;
        win_idx = ptr + 2'(i);
      end
    end
  end

  assign others    = |(req & ~(4'b0001 << select));
  assign burst_hit = limit_en && (cnt == burst_last) && others;

  // In OWN, ptr is always owner+1, so the scan above already starts after the owner.
  always_comb begin
    take = 1'b0;
    if (win_vld) begin
      if (state == IDLE) take = 1'b1;
      else if (!req[select] || burst_hit) take = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 8'd0;
      grant     <= 4'd0;
      select    <= 2'd0;
      bus_valid <= 1'b0;
    end else if (take) begin
      state     <= OWN;
      grant     <= 4'b0001 << win_idx;
      select    <= win_idx;
      ptr       <= win_idx + 2'd1;
      cnt       <= 8'd0;
      bus_valid <= 1'b1;
    end else if (state == OWN) begin
      if (!req[select]) begin
        state     <= IDLE;
        grant     <= 4'd0;
        bus_valid <= 1'b0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    bus_data = '0;
    if (bus_valid) begin
      case (select)
        2'd0:    bus_data = input_data0;
        2'd1:    bus_data = input_data1;
        2'd2:    bus_data = input_data2;
        default: bus_data = input_data3;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4: per-cycle comparison against an ownership model plus literal checks.
module tb_bus_arbiter_4;
  localparam int MAXB = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [31:0] d [4];
  logic [3:0]  grant;
  logic [1:0]  select;
  logic [31:0] bus_data;
  logic        bus_valid;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: owner index (-1 = nobody), rotation start, hold count, last select.
  int own = -1;
  int mptr = 0;
  int mcnt = 0;
  int msel = 0;

  logic [3:0] rot [5];
  logic [3:0] burst_exp [9];

  bus_arbiter_4 #(.word_size(32), .max_burst(MAXB)) dut (
    .clk(clk), .reset(reset), .req(req),
    .input_data0(d[0]), .input_data1(d[1]), .input_data2(d[2]), .input_data3(d[3]),
    .grant(grant), .select(select), .bus_data(bus_data), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++)
      if (r[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  function automatic void give(input int w);
    own  = w;
    mptr = (w + 1) % 4;
    mcnt = 0;
    msel = w;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      own = -1; mptr = 0; mcnt = 0; msel = 0;
    end else if (own < 0) begin
      if (req != 4'd0) give(winner(req, mptr));
    end else if (!req[own]) begin
      if (req != 4'd0) give(winner(req, (own + 1) % 4));
      else own = -1;
    end else if (BURST_EN && mcnt == MAXB - 1 && (req & ~(4'(1) << own)) != 4'd0) begin
      give(winner(req, (own + 1) % 4));
    end else if (mcnt < 255) begin
      mcnt = mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_grant", 32'(grant), (own < 0) ? 32'd0 : (32'd1 << own));
      check("model_select", 32'(select), 32'(msel));
      check("model_valid", 32'(bus_valid), (own < 0) ? 32'd0 : 32'd1);
      check("model_data", bus_data, (own < 0) ? 32'd0 : d[own]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    d[0] = 32'hA0A0_A0A0;
    d[1] = 32'h1111_1111;
    d[2] = 32'hC2C2_C2C2;
    d[3] = 32'h3333_3333;
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    if (BURST_EN)
      burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    else
      burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};

    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_select", 32'(select), 32'd0);
      check("idle_valid", 32'(bus_valid), 32'd0);
      check("idle_data", bus_data, 32'd0);
    end

    // Two requesters, zero-gap handover on release.
    req = 4'b1010;
    tick();
    check("first_grant", 32'(grant), 32'h2);
    check("first_data", bus_data, 32'h1111_1111);
    req = 4'b1000;
    tick();
    check("handover_grant", 32'(grant), 32'h8);
    check("handover_select", 32'(select), 32'd3);
    check("handover_data", bus_data, 32'h3333_3333);
    req = 4'b0000;
    tick();
    check("release_grant", 32'(grant), 32'd0);
    check("release_select_hold", 32'(select), 32'd3);
    check("release_data", bus_data, 32'd0);

    // Full rotation with each owner dropping after one granted cycle.
    req = 4'b1111;
    tick();
    check("rot_grant_0", 32'(grant), 32'(rot[0]));
    for (int i = 1; i < 5; i++) begin
      req = 4'b1111 & ~rot[i-1];
      tick();
      check("rot_grant", 32'(grant), 32'(rot[i]));
    end
    req = 4'b0000;
    tick();
    check("rot_idle", 32'(grant), 32'd0);

    // Burst: requester 0 holds, requester 2 arrives during its ownership.
    req = 4'b0001;
    tick();
    check("burst_grant_1", 32'(grant), 32'(burst_exp[0]));
    req = 4'b0101;
    for (int i = 1; i < 9; i++) begin
      tick();
      check("burst_grant", 32'(grant), 32'(burst_exp[i]));
    end
    req = 4'b0100;
    tick();
    check("burst_drop0", 32'(grant), 32'h4);
    check("burst_drop0_data", bus_data, 32'hC2C2_C2C2);

    // Asynchronous reset while requester 2 owns the bus.
    reset = 1'b1;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_select", 32'(select), 32'd0);
    check("arst_valid", 32'(bus_valid), 32'd0);
    check("arst_data", bus_data, 32'd0);
    req = 4'b0110;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_grant", 32'(grant), 32'h2);
    check("post_reset_select", 32'(select), 32'd1);

    // Long single-owner hold across count saturation.
    req = 4'b1000;
    for (int i = 0; i < 300; i++) begin
      tick();
      check("long_hold", 32'(grant), 32'h8);
    end
    req = 4'b0000;
    tick();
    check("long_release", 32'(grant), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
